// File: rtl/lcd_button_pkg.sv
// lcd_button_pkg
// Shared types and constants for the LCD push-button conditioning path.
//   btn_state_t             : debounce FSM state encoding
//   PRESS_CNT_W             : width of the wrapping press counter
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms hold time at a 50 MHz clock
package lcd_button_pkg;

    localparam int PRESS_CNT_W             = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_t;

endpackage

// File: rtl/lcd_sync_2ff.sv
// lcd_sync_2ff
// Two-flop synchroniser for a single asynchronous board input.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk edges after d is sampled
module lcd_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lcd_button_debounce.sv
// lcd_button_debounce
// Synchronises and debounces the LCD board push-button, producing a clean
// level for the button PIO plus press/release strobes and a press counter.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   RELEASED     | key stable up, level = 0
//   WAIT_PRESS   | key seen down, counting hold time before accepting
//   PRESSED      | key stable down, level = 1
//   WAIT_RELEASE | key seen up, counting hold time before accepting
//
// Ports:
//   clk           : system clock
//   reset         : synchronous, active-high
//   button_raw    : asynchronous key pin (polarity set by ACTIVE_LOW)
//   count_clr     : synchronous clear of press_count
//   button_level  : debounced level, 1 = pressed
//   press_pulse   : one-cycle strobe on accepted press
//   release_pulse : one-cycle strobe on accepted release
//   press_count   : accepted presses modulo 256
// All outputs come straight from flops.
module lcd_button_debounce
    import lcd_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   button_raw,
    input  logic                   count_clr,
    output logic                   button_level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pin_norm;
    logic             sync;
    logic             level_next, press_next, release_next;

    // Normalise polarity ahead of the synchroniser so 1 always means pressed
    // and the synchroniser's reset value is simply "not pressed".
    assign pin_norm = ACTIVE_LOW ? ~button_raw : button_raw;

    lcd_sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin_norm),
        .q     (sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Any return to the stable state clears the count: no partial credit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (sync) begin
                    state_next = WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!sync) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_next = WAIT_RELEASE;
                    cnt_next   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the transition and registered, so level and
    // strobe update on the same edge as the accepting state change.
    always_comb begin
        level_next   = (state_next == PRESSED) || (state_next == WAIT_RELEASE);
        press_next   = (state == WAIT_PRESS)   && (state_next == PRESSED);
        release_next = (state == WAIT_RELEASE) && (state_next == RELEASED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            button_level  <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            button_level  <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

    // The counter consumes the registered strobe; a clear coinciding with the
    // strobe still counts that press.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_count <= '0;
        end else if (count_clr) begin
            press_count <= press_pulse ? PRESS_CNT_W'(1) : '0;
        end else if (press_pulse) begin
            press_count <= press_count + PRESS_CNT_W'(1);
        end
    end

endmodule
